// File: rtl/ro_ser_pkg.sv
// Shared constants, frame-type enum and header helper for the framed readout serializer.
package ro_ser_pkg;

  localparam int unsigned FRAME_LEN = 32;
  localparam int unsigned HDR_W     = 2;

  localparam logic [HDR_W-1:0] HDR_DATA = 2'b10;
  localparam logic [HDR_W-1:0] HDR_IDLE = 2'b01;

  localparam logic [29:0] IDLE_PATTERN_DEF = 30'h2AAAAAAA;

  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_DATA = 1'b1
  } frame_t;

  function automatic logic [HDR_W-1:0] frame_hdr(input frame_t t);
    return (t == FR_DATA) ? HDR_DATA : HDR_IDLE;
  endfunction

endpackage

// File: rtl/ro_frame_serializer_if.sv
// Upstream valid/ready word handshake between the readout selector and the serializer.
interface ro_frame_serializer_if #(
  parameter int unsigned DATA_WIDTH = 30
);
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  DataValid;
  logic                  DataReady;

  modport master (output DataIn, output DataValid, input DataReady);
  modport slave  (input DataIn, input DataValid, output DataReady);
endinterface

// File: rtl/ro_sync_fifo.sv
// Small in-order synchronous FIFO; head word is visible on rdata while not empty.
module ro_sync_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (level == LVL_W'(DEPTH));
  assign empty_c = (level == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
      else if (pop_ok && !push_ok) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/ro_frame_serializer.sv
// Framed serial output stage: queues readout words and emits 32-bit data or idle frames back to back.
module ro_frame_serializer
  import ro_ser_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 30,
  parameter int unsigned           FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = DATA_WIDTH'(IDLE_PATTERN_DEF),
  parameter int unsigned           CNT_WIDTH    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  ro_frame_serializer_if.slave          up,
  output logic                          SerOut,
  output logic                          FrameStart,
  output logic [CNT_WIDTH-1:0]          FrameCnt,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);
  localparam int unsigned BIT_W = $clog2(FRAME_LEN);

  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_LEN-1:0]  shreg;
  logic [FRAME_LEN-1:0]  frame_c;
  logic [DATA_WIDTH-1:0] head;
  frame_t                frame_type_c;
  logic                  frame_edge_c;
  logic                  fifo_full_c;
  logic                  fifo_empty_c;
  logic                  push_c;
  logic                  pop_c;

  assign up.DataReady = !reset && !fifo_full_c;
  assign push_c       = up.DataValid && up.DataReady;
  assign frame_edge_c = (bit_cnt == '0);
  assign pop_c        = frame_edge_c && !fifo_empty_c;

  ro_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (up.DataIn),
    .rdata   (head),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (FifoLevel)
  );

  // Frame selected at a frame boundary: queued head word if any, else idle filler.
  always_comb begin
    frame_type_c = FR_IDLE;
    if (!fifo_empty_c) frame_type_c = FR_DATA;
    frame_c = {frame_hdr(frame_type_c), (frame_type_c == FR_DATA) ? head : IDLE_PATTERN};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      SerOut     <= 1'b0;
      FrameStart <= 1'b0;
      FrameCnt   <= '0;
    end else begin
      bit_cnt <= (bit_cnt == BIT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + BIT_W'(1);
      if (frame_edge_c) begin
        SerOut     <= frame_c[FRAME_LEN-1];
        shreg      <= {frame_c[FRAME_LEN-2:0], 1'b0};
        FrameStart <= 1'b1;
        if (frame_type_c == FR_DATA) FrameCnt <= FrameCnt + CNT_WIDTH'(1);
      end else begin
        SerOut     <= shreg[FRAME_LEN-1];
        shreg      <= {shreg[FRAME_LEN-2:0], 1'b0};
        FrameStart <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ro_frame_serializer.sv
// Directed self-checking bench for ro_frame_serializer.
module tb_ro_frame_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       SerOut;
  logic       FrameStart;
  logic [7:0] FrameCnt;
  logic [2:0] FifoLevel;
  int         checks = 0;
  int         errors = 0;

  ro_frame_serializer_if #(.DATA_WIDTH(30)) up ();

  ro_frame_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .up         (up),
    .SerOut     (SerOut),
    .FrameStart (FrameStart),
    .FrameCnt   (FrameCnt),
    .FifoLevel  (FifoLevel)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    up.DataValid = 1'b0;
    up.DataIn = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up.DataValid = 1'b1;
    up.DataIn = 30'h155;
    repeat (3) tick();
    checks++; if (SerOut !== 1'b0) begin errors++; $display("FAIL rst_serout got %b exp 0", SerOut); end
    checks++; if (FrameStart !== 1'b0) begin errors++; $display("FAIL rst_framestart got %b exp 0", FrameStart); end
    checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL rst_framecnt got %0d exp 0", FrameCnt); end
    checks++; if (FifoLevel !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", FifoLevel); end
    checks++; if (up.DataReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", up.DataReady); end
    up.DataValid = 1'b0;
  endtask

  task automatic test_idle();
    logic [31:0] idle_frm;
    logic        exp_bit;
    logic        exp_fs;
    idle_frm = 32'h6AAAAAAA;
    do_reset(2);
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp_bit = idle_frm[31 - ((k - 1) % 32)];
      exp_fs  = ((k - 1) % 32 == 0);
      checks++; if (SerOut !== exp_bit) begin errors++; $display("FAIL idle_bit cyc %0d got %b exp %b", k, SerOut, exp_bit); end
      checks++; if (FrameStart !== exp_fs) begin errors++; $display("FAIL idle_fs cyc %0d got %b exp %b", k, FrameStart, exp_fs); end
    end
    checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL idle_framecnt got %0d exp 0", FrameCnt); end
  endtask

  task automatic test_single_word();
    logic [31:0] rx;
    rx = '0;
    do_reset(2);
    for (int k = 1; k <= 64; k++) begin
      up.DataValid = (k == 5);
      up.DataIn    = 30'h12345678;
      tick();
      rx = {rx[30:0], SerOut};
      if (k == 5) begin
        checks++; if (FifoLevel !== 3'd1) begin errors++; $display("FAIL single_level_push got %0d exp 1", FifoLevel); end
      end
      if (k == 32) begin
        checks++; if (rx !== 32'h6AAAAAAA) begin errors++; $display("FAIL single_first_idle got %h exp 6aaaaaaa", rx); end
        checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL single_cnt_pre got %0d exp 0", FrameCnt); end
      end
      if (k == 33) begin
        checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL single_fs got %b exp 1", FrameStart); end
        checks++; if (FrameCnt !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", FrameCnt); end
        checks++; if (FifoLevel !== 3'd0) begin errors++; $display("FAIL single_level_pop got %0d exp 0", FifoLevel); end
      end
      if (k == 64) begin
        checks++; if (rx !== 32'h92345678) begin errors++; $display("FAIL single_data_frame got %h exp 92345678", rx); end
      end
    end
    up.DataValid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] rx;
    logic [31:0] exp_f;
    logic        acc;
    int          idx;
    rx  = '0;
    idx = 0;
    do_reset(2);
    for (int k = 1; k <= 224; k++) begin
      up.DataValid = (k >= 2) && (idx < 6);
      up.DataIn    = 30'(2000 + 3 * idx);
      acc = up.DataValid && up.DataReady;
      tick();
      if (acc) idx++;
      rx = {rx[30:0], SerOut};
      if (k % 32 == 0) begin
        exp_f = (k == 32) ? 32'h6AAAAAAA : (32'h80000000 | 32'(2000 + 3 * (k / 32 - 2)));
        checks++; if (rx !== exp_f) begin errors++; $display("FAIL bp_frame cyc %0d got %h exp %h", k, rx, exp_f); end
      end
      if (k == 5) begin
        checks++; if (FifoLevel !== 3'd4) begin errors++; $display("FAIL bp_level_full got %0d exp 4", FifoLevel); end
        checks++; if (up.DataReady !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", up.DataReady); end
      end
      if (k == 32) begin
        checks++; if (up.DataReady !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got %b exp 0", up.DataReady); end
      end
      if (k == 33) begin
        checks++; if (up.DataReady !== 1'b1) begin errors++; $display("FAIL bp_ready_pop got %b exp 1", up.DataReady); end
        checks++; if (FifoLevel !== 3'd3) begin errors++; $display("FAIL bp_level_pop got %0d exp 3", FifoLevel); end
      end
      if (k == 34) begin
        checks++; if (FifoLevel !== 3'd4) begin errors++; $display("FAIL bp_level_refill got %0d exp 4", FifoLevel); end
      end
    end
    up.DataValid = 1'b0;
    checks++; if (idx != 6) begin errors++; $display("FAIL bp_accepted got %0d exp 6", idx); end
    checks++; if (FrameCnt !== 8'd6) begin errors++; $display("FAIL bp_framecnt got %0d exp 6", FrameCnt); end
  endtask

  task automatic test_coincide();
    do_reset(2);
    for (int k = 1; k <= 34; k++) begin
      up.DataValid = (k == 2) || (k == 3) || (k == 33);
      up.DataIn    = 30'(100 + k);
      tick();
      if (k == 32) begin
        checks++; if (FifoLevel !== 3'd2) begin errors++; $display("FAIL coin_level_pre got %0d exp 2", FifoLevel); end
      end
      if (k == 33) begin
        checks++; if (FifoLevel !== 3'd2) begin errors++; $display("FAIL coin_level got %0d exp 2", FifoLevel); end
        checks++; if (FrameCnt !== 8'd1) begin errors++; $display("FAIL coin_cnt got %0d exp 1", FrameCnt); end
        checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL coin_hdr got %b exp 1", SerOut); end
      end
    end
    up.DataValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_f;
    exp_f = {2'b10, 30'h0ABCDE02};
    do_reset(2);
    for (int k = 1; k <= 48; k++) begin
      up.DataValid = (k >= 2) && (k <= 5);
      up.DataIn    = 30'h0ABCDE00 + 30'(k);
      tick();
    end
    up.DataValid = 1'b0;
    checks++; if (SerOut !== exp_f[16]) begin errors++; $display("FAIL mid_bit15 got %b exp %b", SerOut, exp_f[16]); end
    checks++; if (FifoLevel !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d exp 3", FifoLevel); end
    reset = 1'b1;
    tick();
    checks++; if (SerOut !== 1'b0) begin errors++; $display("FAIL mid_serout got %b exp 0", SerOut); end
    checks++; if (FifoLevel !== 3'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", FifoLevel); end
    checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", FrameCnt); end
    reset = 1'b0;
    tick();
    checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL mid_restart_fs got %b exp 1", FrameStart); end
    checks++; if (SerOut !== 1'b0) begin errors++; $display("FAIL mid_idle_hdr0 got %b exp 0", SerOut); end
    tick();
    checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL mid_idle_hdr1 got %b exp 1", SerOut); end
    checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL mid_idle_cnt got %0d exp 0", FrameCnt); end
  endtask

  task automatic test_wrap();
    do_reset(2);
    up.DataValid = 1'b1;
    up.DataIn    = 30'h3FFFFFFF;
    for (int k = 1; k <= 8193; k++) begin
      tick();
      if (k == 8160) begin
        checks++; if (FrameCnt !== 8'd254) begin errors++; $display("FAIL wrap_254 got %0d exp 254", FrameCnt); end
      end
      if (k == 8161) begin
        checks++; if (FrameCnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", FrameCnt); end
      end
      if (k == 8193) begin
        checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", FrameCnt); end
        checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL wrap_fs got %b exp 1", FrameStart); end
        checks++; if (SerOut !== 1'b1) begin errors++; $display("FAIL wrap_hdr got %b exp 1", SerOut); end
      end
    end
    up.DataValid = 1'b0;
  endtask

  initial begin
    up.DataValid = 1'b0;
    up.DataIn    = '0;
    test_reset();
    test_idle();
    test_single_word();
    test_backpressure();
    test_coincide();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
